// File: rtl/branch_predictor_btb.sv
// rtl/branch_predictor_btb.sv - branch target buffer with saturating-counter direction prediction
// Flop-based table, zero-latency lookup, non-speculative GHR, saturating statistics.
module branch_predictor_btb #(
  parameter int ADDR_W     = 32,
  parameter int INDEX_BITS = 4,
  parameter int CTR_BITS   = 2,
  parameter int MODE       = 0,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_W-1:0]     pred_pc,
  output logic                  pred_hit,
  output logic                  pred_taken,
  output logic [ADDR_W-1:0]     pred_target,
  output logic [INDEX_BITS-1:0] pred_index,
  input  logic                  upd_valid,
  input  logic [ADDR_W-1:0]     upd_pc,
  input  logic [INDEX_BITS-1:0] upd_index,
  input  logic                  upd_is_jump,
  input  logic                  upd_taken,
  input  logic [ADDR_W-1:0]     upd_target,
  input  logic                  upd_mispredict,
  output logic [CNT_W-1:0]      stat_resolved,
  output logic [CNT_W-1:0]      stat_mispred
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam int TAG_W   = ADDR_W - INDEX_BITS - 2;
  localparam logic [CTR_BITS-1:0] CTR_MAX = {CTR_BITS{1'b1}};
  localparam logic [CTR_BITS-1:0] CTR_WT  = {1'b1, {(CTR_BITS-1){1'b0}}};
  localparam logic [CTR_BITS-1:0] CTR_WNT = ~CTR_WT;

  logic                  valid_q  [ENTRIES];
  logic [TAG_W-1:0]      tag_q    [ENTRIES];
  logic [ADDR_W-1:0]     target_q [ENTRIES];
  logic [CTR_BITS-1:0]   ctr_q    [ENTRIES];
  logic                  jump_q   [ENTRIES];
  logic [INDEX_BITS-1:0] ghr_q;

  logic [INDEX_BITS-1:0] base;
  logic                  upd_hit;
  logic [INDEX_BITS-1:0] ghr_next;
  logic                  unused_pc_bits;

  assign unused_pc_bits = ^{pred_pc[1:0], upd_pc[INDEX_BITS+1:0]};

  // Lookup reads the registered table only, so a same-cycle update is seen one cycle later.
  always_comb begin
    base        = pred_pc[INDEX_BITS+1:2];
    pred_index  = (MODE == 1) ? (base ^ ghr_q) : base;
    pred_hit    = valid_q[pred_index] && (tag_q[pred_index] == pred_pc[ADDR_W-1:INDEX_BITS+2]);
    pred_taken  = pred_hit && (jump_q[pred_index] || ctr_q[pred_index][CTR_BITS-1]);
    pred_target = pred_taken ? target_q[pred_index] : pred_pc + ADDR_W'(4);
  end

  assign upd_hit  = valid_q[upd_index] && (tag_q[upd_index] == upd_pc[ADDR_W-1:INDEX_BITS+2]);
  assign ghr_next = (ghr_q << 1) | INDEX_BITS'(upd_taken);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_WNT;
        jump_q[i]   <= 1'b0;
      end
      ghr_q         <= '0;
      stat_resolved <= '0;
      stat_mispred  <= '0;
    end else begin
      if (upd_valid) begin
        if (upd_hit) begin
          if (upd_is_jump) begin
            ctr_q[upd_index]    <= CTR_MAX;
            target_q[upd_index] <= upd_target;
          end else if (upd_taken) begin
            if (ctr_q[upd_index] != CTR_MAX)
              ctr_q[upd_index] <= ctr_q[upd_index] + CTR_BITS'(1);
            target_q[upd_index] <= upd_target;
          end else if (ctr_q[upd_index] != '0) begin
            ctr_q[upd_index] <= ctr_q[upd_index] - CTR_BITS'(1);
          end
        end else if (upd_taken) begin
          valid_q[upd_index]  <= 1'b1;
          tag_q[upd_index]    <= upd_pc[ADDR_W-1:INDEX_BITS+2];
          target_q[upd_index] <= upd_target;
          jump_q[upd_index]   <= upd_is_jump;
          ctr_q[upd_index]    <= upd_is_jump ? CTR_MAX : CTR_WT;
        end
        if (!upd_is_jump)
          ghr_q <= ghr_next;
      end
      if (upd_valid && (stat_resolved != {CNT_W{1'b1}}))
        stat_resolved <= stat_resolved + CNT_W'(1);
      if (upd_valid && upd_mispredict && (stat_mispred != {CNT_W{1'b1}}))
        stat_mispred <= stat_mispred + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_predictor_btb.sv
// tb/tb_branch_predictor_btb.sv - self-checking bench for branch_predictor_btb
// Three instances (bimodal, gshare, 2-bit stats) share stimulus; one table-level model covers all.
module tb_branch_predictor_btb;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pred_pc, upd_pc, upd_target;
  logic        upd_valid, upd_is_jump, upd_taken, upd_mispredict;
  logic [3:0]  upd_index;

  logic        a_hit, a_taken, b_hit, b_taken, c_hit, c_taken;
  logic [31:0] a_target, b_target, c_target;
  logic [3:0]  a_index, b_index, c_index;
  logic [15:0] a_sres, a_smis, b_sres, b_smis;
  logic [1:0]  c_sres, c_smis;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  branch_predictor_btb #(.MODE(0)) u_a (
    .clk(clk), .rst(rst), .pred_pc(pred_pc), .pred_hit(a_hit), .pred_taken(a_taken),
    .pred_target(a_target), .pred_index(a_index), .upd_valid(upd_valid), .upd_pc(upd_pc),
    .upd_index(upd_index), .upd_is_jump(upd_is_jump), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_mispredict(upd_mispredict),
    .stat_resolved(a_sres), .stat_mispred(a_smis));

  branch_predictor_btb #(.MODE(1)) u_b (
    .clk(clk), .rst(rst), .pred_pc(pred_pc), .pred_hit(b_hit), .pred_taken(b_taken),
    .pred_target(b_target), .pred_index(b_index), .upd_valid(upd_valid), .upd_pc(upd_pc),
    .upd_index(upd_index), .upd_is_jump(upd_is_jump), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_mispredict(upd_mispredict),
    .stat_resolved(b_sres), .stat_mispred(b_smis));

  branch_predictor_btb #(.MODE(0), .CNT_W(2)) u_c (
    .clk(clk), .rst(rst), .pred_pc(pred_pc), .pred_hit(c_hit), .pred_taken(c_taken),
    .pred_target(c_target), .pred_index(c_index), .upd_valid(upd_valid), .upd_pc(upd_pc),
    .upd_index(upd_index), .upd_is_jump(upd_is_jump), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_mispredict(upd_mispredict),
    .stat_resolved(c_sres), .stat_mispred(c_smis));

  // Reference model: table contents as plain arrays, counters as integers.
  bit          m_valid [16];
  logic [31:0] m_tag   [16];
  logic [31:0] m_tgt   [16];
  int          m_ctr   [16];
  bit          m_jump  [16];
  int          m_ghr;
  longint      m_res, m_mis;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_lookup(input logic [31:0] pc, input int mode, output logic hit,
                              output logic taken, output logic [31:0] target, output logic [3:0] index);
    int idx;
    idx    = int'((pc >> 2) & 32'hF) ^ (mode == 1 ? m_ghr : 0);
    index  = 4'(idx);
    hit    = m_valid[idx] && (m_tag[idx] == (pc >> 6));
    taken  = hit && (m_jump[idx] || m_ctr[idx] >= 2);
    target = taken ? m_tgt[idx] : pc + 32'd4;
  endtask

  task automatic model_update();
    int i;
    if (rst) begin
      for (int k = 0; k < 16; k++) begin
        m_valid[k] = 0; m_tag[k] = 0; m_tgt[k] = 0; m_ctr[k] = 1; m_jump[k] = 0;
      end
      m_ghr = 0; m_res = 0; m_mis = 0;
    end else if (upd_valid) begin
      i = int'(upd_index);
      if (m_valid[i] && m_tag[i] == (upd_pc >> 6)) begin
        if (upd_is_jump) begin
          m_ctr[i] = 3; m_tgt[i] = upd_target;
        end else if (upd_taken) begin
          m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3; m_tgt[i] = upd_target;
        end else begin
          m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
        end
      end else if (upd_taken) begin
        m_valid[i] = 1; m_tag[i] = upd_pc >> 6; m_tgt[i] = upd_target;
        m_jump[i] = upd_is_jump; m_ctr[i] = upd_is_jump ? 3 : 2;
      end
      if (!upd_is_jump) m_ghr = ((m_ghr << 1) | int'(upd_taken)) & 15;
      m_res++;
      if (upd_mispredict) m_mis++;
    end
  endtask

  task automatic compare_model();
    logic h, t;
    logic [31:0] g;
    logic [3:0] x;
    model_lookup(pred_pc, 0, h, t, g, x);
    check("a_hit", a_hit, h); check("a_taken", a_taken, t);
    check("a_target", a_target, g); check("a_index", a_index, x);
    check("c_hit", c_hit, h); check("c_target", c_target, g);
    model_lookup(pred_pc, 1, h, t, g, x);
    check("b_hit", b_hit, h); check("b_taken", b_taken, t);
    check("b_target", b_target, g); check("b_index", b_index, x);
    check("a_sres", a_sres, (m_res > 65535) ? 65535 : m_res);
    check("a_smis", a_smis, (m_mis > 65535) ? 65535 : m_mis);
    check("c_sres", c_sres, (m_res > 3) ? 3 : m_res);
    check("c_smis", c_smis, (m_mis > 3) ? 3 : m_mis);
  endtask

  // Called at the falling edge with inputs settled; advances through one rising edge.
  task automatic step(input bit do_cmp);
    if (do_cmp) compare_model();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic drive(input logic [31:0] pc, input logic uv, input logic [31:0] upc,
                       input logic [3:0] uidx, input logic uj, input logic ut,
                       input logic [31:0] utgt, input logic um);
    pred_pc = pc; upd_valid = uv; upd_pc = upc; upd_index = uidx;
    upd_is_jump = uj; upd_taken = ut; upd_target = utgt; upd_mispredict = um;
  endtask

  function automatic logic [31:0] rand_pc();
    if ($urandom_range(0, 9) == 0) return $urandom;
    return {24'h0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 2'b00};
  endfunction

  typedef struct {
    logic [31:0] pc;
    logic        uv;
    logic [31:0] upc;
    logic [3:0]  uidx;
    logic        uj, ut;
    logic [31:0] utgt;
    logic        ehit, etaken;
    logic [31:0] etgt;
    logic [3:0]  eidx;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [31:0] pc, input logic uv, input logic [31:0] upc,
                     input logic [3:0] uidx, input logic uj, input logic ut, input logic [31:0] utgt,
                     input logic ehit, input logic etaken, input logic [31:0] etgt, input logic [3:0] eidx);
    vec_t v;
    v.pc = pc; v.uv = uv; v.upc = upc; v.uidx = uidx; v.uj = uj; v.ut = ut; v.utgt = utgt;
    v.ehit = ehit; v.etaken = etaken; v.etgt = etgt; v.eidx = eidx;
    tbl.push_back(v);
  endtask

  initial begin
    // pc, upd_valid, upd_pc, upd_index, jump, taken, upd_target | hit, taken, target, index
    add(32'h40, 0, 32'h0,  4'd0, 0, 0, 32'h0,   0, 0, 32'h44,  4'd0);
    add(32'h40, 1, 32'h40, 4'd0, 0, 1, 32'h100, 0, 0, 32'h44,  4'd0);
    add(32'h40, 0, 32'h0,  4'd0, 0, 0, 32'h0,   1, 1, 32'h100, 4'd0);
    add(32'h40, 1, 32'h40, 4'd0, 0, 0, 32'h0,   1, 1, 32'h100, 4'd0);
    add(32'h40, 1, 32'h40, 4'd0, 0, 0, 32'h0,   1, 0, 32'h44,  4'd0);
    add(32'h40, 1, 32'h40, 4'd0, 0, 1, 32'h100, 1, 0, 32'h44,  4'd0);
    add(32'h40, 1, 32'h40, 4'd0, 0, 1, 32'h100, 1, 0, 32'h44,  4'd0);
    add(32'h40, 1, 32'h40, 4'd0, 0, 1, 32'h100, 1, 1, 32'h100, 4'd0);
    add(32'h40, 1, 32'h40, 4'd0, 0, 1, 32'h104, 1, 1, 32'h100, 4'd0);
    add(32'h40, 1, 32'h40, 4'd0, 0, 0, 32'h0,   1, 1, 32'h104, 4'd0);
    add(32'h40, 0, 32'h0,  4'd0, 0, 0, 32'h0,   1, 1, 32'h104, 4'd0);
    add(32'h60, 1, 32'h60, 4'd8, 1, 1, 32'h300, 0, 0, 32'h64,  4'd8);
    add(32'h60, 1, 32'h60, 4'd8, 1, 1, 32'h304, 1, 1, 32'h300, 4'd8);
    add(32'h60, 0, 32'h0,  4'd0, 0, 0, 32'h0,   1, 1, 32'h304, 4'd8);
    add(32'h80, 0, 32'h0,  4'd0, 0, 0, 32'h0,   0, 0, 32'h84,  4'd0);
    add(32'h80, 1, 32'h80, 4'd0, 0, 1, 32'h200, 0, 0, 32'h84,  4'd0);
    add(32'h80, 0, 32'h0,  4'd0, 0, 0, 32'h0,   1, 1, 32'h200, 4'd0);
    add(32'h40, 0, 32'h0,  4'd0, 0, 0, 32'h0,   0, 0, 32'h44,  4'd0);
    add(32'hC0, 1, 32'hC0, 4'd0, 0, 0, 32'h0,   0, 0, 32'hC4,  4'd0);
    add(32'h80, 0, 32'h0,  4'd0, 0, 0, 32'h0,   1, 1, 32'h200, 4'd0);
    add(32'hFFFFFFFC, 0, 32'h0, 4'd0, 0, 0, 32'h0, 0, 0, 32'h0, 4'd15);

    rst = 1'b1;
    drive(32'h40, 0, 0, 0, 0, 0, 0, 0);
    #4; step(0);
    rst = 1'b0;

    foreach (tbl[k]) begin
      drive(tbl[k].pc, tbl[k].uv, tbl[k].upc, tbl[k].uidx, tbl[k].uj, tbl[k].ut, tbl[k].utgt, 0);
      #4;
      check($sformatf("v%0d_hit", k), a_hit, tbl[k].ehit);
      check($sformatf("v%0d_taken", k), a_taken, tbl[k].etaken);
      check($sformatf("v%0d_target", k), a_target, tbl[k].etgt);
      check($sformatf("v%0d_index", k), a_index, tbl[k].eidx);
      step(1);
    end

    // Statistics: 5 resolutions with 2 mispredicts, then push the 2-bit counters past saturation.
    rst = 1'b1; drive(32'h40, 0, 0, 0, 0, 0, 0, 0); #4; step(1); rst = 1'b0;
    for (int n = 0; n < 5; n++) begin
      drive(32'h40, 1, 32'h40, 4'd0, 0, 0, 32'h0, (n == 1 || n == 3));
      #4; step(1);
    end
    drive(32'h40, 0, 0, 0, 0, 0, 0, 0); #4;
    check("stat_res5", a_sres, 16'd5); check("stat_mis2", a_smis, 16'd2);
    check("c_stat_res_sat", c_sres, 2'd3); check("c_stat_mis2", c_smis, 2'd2);
    step(1);
    for (int n = 0; n < 2; n++) begin
      drive(32'h40, 1, 32'h40, 4'd0, 0, 0, 32'h0, 1); #4; step(1);
    end
    drive(32'h40, 0, 0, 0, 0, 0, 0, 0); #4;
    check("stat_mis4", a_smis, 16'd4); check("c_stat_mis_sat", c_smis, 2'd3);
    step(1);

    // Gshare: one taken branch shifts a 1 into the history.
    rst = 1'b1; #4; step(1); rst = 1'b0;
    drive(32'h40, 1, 32'h40, 4'd0, 0, 1, 32'h100, 0); #4; step(1);
    drive(32'h40, 0, 0, 0, 0, 0, 0, 0); #4;
    check("g_index1", b_index, 4'd1); check("g_hit0", b_hit, 1'b0);
    step(1);
    drive(32'h44, 0, 0, 0, 0, 0, 0, 0); #4;
    check("g_index0", b_index, 4'd0); check("g_hit1", b_hit, 1'b1);
    check("g_target", b_target, 32'h100);
    step(1);

    // Reset coinciding with an update discards the update.
    rst = 1'b1; drive(32'h40, 1, 32'h40, 4'd0, 0, 1, 32'h500, 1); #4; step(1); rst = 1'b0;
    drive(32'h40, 0, 0, 0, 0, 0, 0, 0); #4;
    check("rst_upd_hit", a_hit, 1'b0); check("rst_upd_target", a_target, 32'h44);
    check("rst_upd_sres", a_sres, 16'd0); check("rst_upd_smis", a_smis, 16'd0);
    check("rst_upd_ghr", b_index, 4'd0);
    step(1);

    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 59) == 0);
      upd_pc = rand_pc();
      drive(rand_pc(), ($urandom_range(0, 2) != 0), upd_pc,
            ($urandom_range(0, 1) == 1) ? upd_pc[5:2] : 4'($urandom),
            ($urandom_range(0, 4) == 0), 1'($urandom), $urandom & 32'hFFFF_FFFC, 1'($urandom));
      #4; step(1);
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
